// File: rtl/clk_sched_pkg.sv
// Shared types and constants for the clock-phase scheduler.
// Holds the FSM state enum, the phase strobe indices and the minimum legal divide ratio.
package clk_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int unsigned NUM_PH  = 4;
  localparam logic [1:0]  PH_IMEM = 2'd0;
  localparam logic [1:0]  PH_PROC = 2'd1;
  localparam logic [1:0]  PH_DMEM = 2'd2;
  localparam logic [1:0]  PH_REG  = 2'd3;

  localparam int unsigned MIN_DIV = 4;

endpackage

// File: rtl/clk_phase_sched_if.sv
// Control/status bus of the clock-phase scheduler.
// CLK_SCHED_CYCLE_CNT_EN adds the 32-bit cycle_count status signal.
interface clk_phase_sched_if #(
  parameter int unsigned CNT_W = 8
);
  logic             run;
  logic             stall;
  logic             div_req;
  logic [CNT_W-1:0] div_val;
  logic             div_ack;
  logic             div_err;
  logic [CNT_W-1:0] div_cur;
  logic [3:0]       phase_en;
  logic             clk_out;
  logic             busy;
`ifdef CLK_SCHED_CYCLE_CNT_EN
  logic [31:0]      cycle_count;

  modport master (
    output run, stall, div_req, div_val,
    input  div_ack, div_err, div_cur, phase_en, clk_out, busy, cycle_count
  );
  modport slave (
    input  run, stall, div_req, div_val,
    output div_ack, div_err, div_cur, phase_en, clk_out, busy, cycle_count
  );
`else
  modport master (
    output run, stall, div_req, div_val,
    input  div_ack, div_err, div_cur, phase_en, clk_out, busy
  );
  modport slave (
    input  run, stall, div_req, div_val,
    output div_ack, div_err, div_cur, phase_en, clk_out, busy
  );
`endif
endinterface

// File: rtl/clk_sched_ratio.sv
// Divide-ratio holder: div_req/div_ack handshake, range check, div_cur and quarter registers.
// A request is taken only while window is high; the new ratio applies from the next cnt=0.
module clk_sched_ratio
  import clk_sched_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 8
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             window,
  input  logic             div_req,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic [CNT_W-1:0] div_cur,
  output logic [CNT_W-1:0] quarter
);

  logic consume;
  logic range_ok;

  // The ack cycle itself is blocked so a still-high div_req is not taken twice.
  assign consume  = window && div_req && !div_ack;
  assign range_ok = (div_val >= CNT_W'(MIN_DIV));

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      div_ack <= 1'b0;
      div_err <= 1'b0;
      div_cur <= CNT_W'(DEFAULT_DIV);
      quarter <= CNT_W'(DEFAULT_DIV >> 2);
    end else begin
      div_ack <= consume;
      div_err <= consume && !range_ok;
      if (consume && range_ok) begin
        div_cur <= div_val;
        quarter <= div_val >> 2;
      end
    end
  end

endmodule

// File: rtl/clk_phase_sched.sv
// clk_phase_sched: single-counter clock-enable scheduler for the imem/proc/dmem/regfile phases.
// Optional macro CLK_SCHED_CYCLE_CNT_EN adds a 32-bit count of completed processor cycles.
module clk_phase_sched
  import clk_sched_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 8
) (
  input logic              in_clk,
  input logic              reset,
  clk_phase_sched_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] quarter;
  logic             boundary;
  logic             window;
  logic [3:0]       phase_en_c;
  logic             clk_out_c;
  logic             busy_c;

  assign boundary = (state_q == ST_RUN) && (cnt_q == (div_cur - CNT_W'(1)));
  assign window   = (state_q != ST_RUN) || boundary;

  clk_sched_ratio #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_ratio (
    .in_clk  (in_clk),
    .reset   (reset),
    .window  (window),
    .div_req (bus.div_req),
    .div_val (bus.div_val),
    .div_ack (bus.div_ack),
    .div_err (bus.div_err),
    .div_cur (div_cur),
    .quarter (quarter)
  );

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: stop beats stall at the boundary, and stop beats leaving HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (boundary) begin
          cnt_d = '0;
          if (!bus.run)      state_d = ST_IDLE;
          else if (bus.stall) state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        cnt_d = '0;
        if (!bus.run)       state_d = ST_IDLE;
        else if (!bus.stall) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from registered state and cnt only.
  always_comb begin
    phase_en_c = '0;
    clk_out_c  = 1'b0;
    busy_c     = (state_q == ST_RUN) || (state_q == ST_HOLD);
    if (state_q == ST_RUN) begin
      phase_en_c[PH_IMEM] = (cnt_q == '0);
      phase_en_c[PH_PROC] = (cnt_q == quarter);
      phase_en_c[PH_DMEM] = (cnt_q == (quarter << 1));
      phase_en_c[PH_REG]  = (cnt_q == (quarter + (quarter << 1)));
      clk_out_c           = (cnt_q < (div_cur >> 1));
    end
  end

  assign bus.phase_en = phase_en_c;
  assign bus.clk_out  = clk_out_c;
  assign bus.busy     = busy_c;
  assign bus.div_cur  = div_cur;

`ifdef CLK_SCHED_CYCLE_CNT_EN
  logic [31:0] cycle_q;

  // Every boundary edge ends a processor cycle, whatever state follows.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset)        cycle_q <= '0;
    else if (boundary) cycle_q <= cycle_q + 32'd1;
  end

  assign bus.cycle_count = cycle_q;
`endif

endmodule

// File: tb/tb_clk_phase_sched.sv
// Directed self-checking bench for clk_phase_sched with hand-computed strobe tables.
// Covers reset, ratio 8/12/255 sequencing, rejected ratio, stall/HOLD, stop and mid-cycle reset.
`timescale 1ns/1ps
module tb_clk_phase_sched;

  localparam int unsigned CNT_W = 8;

  logic in_clk = 1'b0;
  logic reset;
  int unsigned total = 0;
  int unsigned bad   = 0;

  // Strobe and clk_out tables indexed by cnt.
  logic [3:0]  ph8  [8]  = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
  logic [7:0]  ck8       = 8'b0000_1111;
  logic [3:0]  ph12 [12] = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0,
                             4'h4, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
  logic [11:0] ck12      = 12'b0000_0011_1111;

  clk_phase_sched_if #(.CNT_W(CNT_W)) bus ();

  clk_phase_sched #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (8)
  ) dut (
    .in_clk (in_clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [3:0] ph, input logic ck, input logic bz);
    check({tag, "_ph"},   32'(bus.phase_en), 32'(ph));
    check({tag, "_clk"},  32'(bus.clk_out),  32'(ck));
    check({tag, "_busy"}, 32'(bus.busy),     32'(bz));
    step();
  endtask

  task automatic span8(input string tag, input int first, input int last);
    for (int c = first; c <= last; c++) expect_cyc(tag, ph8[c], ck8[c], 1'b1);
  endtask

  task automatic span12(input string tag, input int first, input int last);
    for (int c = first; c <= last; c++) expect_cyc(tag, ph12[c], ck12[c], 1'b1);
  endtask

  initial begin
    logic [3:0] exp_ph;

    reset       = 1'b0;
    bus.run     = 1'b0;
    bus.stall   = 1'b0;
    bus.div_req = 1'b0;
    bus.div_val = '0;
    step();
    step();
    check("rst_ph",   32'(bus.phase_en), 32'd0);
    check("rst_clk",  32'(bus.clk_out),  32'd0);
    check("rst_busy", 32'(bus.busy),     32'd0);
    check("rst_ack",  32'(bus.div_ack),  32'd0);
    check("rst_err",  32'(bus.div_err),  32'd0);
    check("rst_div",  32'(bus.div_cur),  32'd8);
`ifdef CLK_SCHED_CYCLE_CNT_EN
    check("rst_cyc",  bus.cycle_count,   32'd0);
`endif
    reset = 1'b1;
    step();

    // Out-of-range ratio in IDLE: ack and err together, ratio kept.
    bus.div_req = 1'b1;
    bus.div_val = 8'd3;
    step();
    check("err_ack", 32'(bus.div_ack), 32'd1);
    check("err_err", 32'(bus.div_err), 32'd1);
    check("err_div", 32'(bus.div_cur), 32'd8);
    bus.div_req = 1'b0;
    step();
    check("err_ack_drop", 32'(bus.div_ack), 32'd0);
    check("err_err_drop", 32'(bus.div_err), 32'd0);

    // Start: phase 0 right after the edge that sees run.
    bus.run = 1'b1;
    step();
    span8("d8a", 0, 7);
    span8("d8b", 0, 7);
    span8("d8c", 0, 1);

    // Ratio 12 requested at cnt=2; ack only after the boundary.
    bus.div_req = 1'b1;
    bus.div_val = 8'd12;
    for (int c = 2; c <= 7; c++) begin
      check("ack_wait", 32'(bus.div_ack), 32'd0);
      expect_cyc("d8c", ph8[c], ck8[c], 1'b1);
    end
    check("chg_ack", 32'(bus.div_ack), 32'd1);
    check("chg_err", 32'(bus.div_err), 32'd0);
    check("chg_div", 32'(bus.div_cur), 32'd12);
    bus.div_req = 1'b0;
    span12("d12a", 0, 11);
    check("chg_ack_drop", 32'(bus.div_ack), 32'd0);
    span12("d12b", 0, 9);

    // Stall high for 5 cycles spanning the boundary.
    bus.stall = 1'b1;
    expect_cyc("st10", 4'h0, 1'b0, 1'b1);
    expect_cyc("st11", 4'h0, 1'b0, 1'b1);
    for (int h = 0; h < 3; h++) expect_cyc("hold", 4'h0, 1'b0, 1'b1);
    bus.stall = 1'b0;
    expect_cyc("hold_last", 4'h0, 1'b0, 1'b1);
    span12("d12c", 0, 2);

    // Stop at cnt=3: cycle completes, then IDLE.
    bus.run = 1'b0;
    span12("d12c", 3, 11);
    expect_cyc("idle0", 4'h0, 1'b0, 1'b0);
    expect_cyc("idle1", 4'h0, 1'b0, 1'b0);
`ifdef CLK_SCHED_CYCLE_CNT_EN
    check("cyc_cnt", bus.cycle_count, 32'd6);
`endif

    // Reset asserted at cnt=5 clears everything at once.
    bus.run = 1'b1;
    step();
    span12("d12d", 0, 4);
    reset = 1'b0;
    #1;
    check("mrst_ph",   32'(bus.phase_en), 32'd0);
    check("mrst_clk",  32'(bus.clk_out),  32'd0);
    check("mrst_busy", 32'(bus.busy),     32'd0);
    check("mrst_ack",  32'(bus.div_ack),  32'd0);
    check("mrst_div",  32'(bus.div_cur),  32'd8);
`ifdef CLK_SCHED_CYCLE_CNT_EN
    check("mrst_cyc",  bus.cycle_count,   32'd0);
`endif
    bus.run = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Largest ratio 255: quarter 63, strobes at 0/63/126/189, period 255.
    bus.div_req = 1'b1;
    bus.div_val = 8'd255;
    step();
    check("max_ack", 32'(bus.div_ack), 32'd1);
    check("max_div", 32'(bus.div_cur), 32'd255);
    bus.div_req = 1'b0;
    bus.run     = 1'b1;
    step();
    for (int c = 0; c <= 255; c++) begin
      case (c)
        0, 255:  exp_ph = 4'h1;
        63:      exp_ph = 4'h2;
        126:     exp_ph = 4'h4;
        189:     exp_ph = 4'h8;
        default: exp_ph = 4'h0;
      endcase
      check("max_ph", 32'(bus.phase_en), 32'(exp_ph));
      if (c == 126) check("max_clk_hi", 32'(bus.clk_out), 32'd1);
      if (c == 127) check("max_clk_lo", 32'(bus.clk_out), 32'd0);
      step();
    end
    bus.run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
